// File: rtl/gfx_fb_writer_pkg.sv
// gfx_fb_writer_pkg: shared defaults and helpers for the framebuffer writer slice.
//   GFX_*_WIDTH  default widths for coordinates, pixel data and addresses
//   STAT_WIDTH   width of the optional statistics counters
//   sat_inc      saturating increment used by the statistics counters
package gfx_fb_writer_pkg;

    localparam int unsigned GFX_H_WIDTH     = 12;
    localparam int unsigned GFX_V_WIDTH     = 12;
    localparam int unsigned GFX_PIXEL_WIDTH = 12;
    localparam int unsigned GFX_ADDR_WIDTH  = 24;
    localparam int unsigned STAT_WIDTH      = 32;

    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] value);
        return (value == '1) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/gfx_fb_addr.sv
// gfx_fb_addr: combinational clip test and linear address generation.
//   x, y                  pixel coordinate
//   h_visible, v_visible  visible area size
//   fb_base               framebuffer base address
//   clip                  high when the coordinate lies outside the visible area
//   addr                  fb_base + y*h_visible + x, modulo 2^ADDR_WIDTH
module gfx_fb_addr
    import gfx_fb_writer_pkg::*;
#(
    parameter int unsigned H_WIDTH    = GFX_H_WIDTH,
    parameter int unsigned V_WIDTH    = GFX_V_WIDTH,
    parameter int unsigned ADDR_WIDTH = GFX_ADDR_WIDTH
) (
    input  logic [H_WIDTH-1:0]    x,
    input  logic [V_WIDTH-1:0]    y,
    input  logic [H_WIDTH-1:0]    h_visible,
    input  logic [V_WIDTH-1:0]    v_visible,
    input  logic [ADDR_WIDTH-1:0] fb_base,
    output logic                  clip,
    output logic [ADDR_WIDTH-1:0] addr
);

    // Wide enough for the full product and for the base, so truncation to
    // ADDR_WIDTH afterwards gives the correct modulo result.
    localparam int unsigned PROD_WIDTH = H_WIDTH + V_WIDTH;
    localparam int unsigned CALC_WIDTH = (ADDR_WIDTH > PROD_WIDTH) ? ADDR_WIDTH : PROD_WIDTH;

    logic [CALC_WIDTH-1:0] sum;

    always_comb begin
        clip = (x >= h_visible) || (y >= v_visible);
        sum  = CALC_WIDTH'(fb_base)
             + CALC_WIDTH'(y) * CALC_WIDTH'(h_visible)
             + CALC_WIDTH'(x);
        addr = sum[ADDR_WIDTH-1:0];
    end

endmodule

// File: rtl/gfx_fb_writer.sv
// gfx_fb_writer: clips a gfx pixel stream and turns visible beats into
// linear framebuffer write requests through a two-stage pipeline.
//   clk, rst_n            clock, synchronous active-low reset
//   s_gfx_*               pixel beat slave port (valid/ready)
//   h_visible, v_visible  visible area size (quasi-static)
//   fb_base               framebuffer base, captured with each beat
//   m_mem_*               memory write master port (valid/ready)
//   idle                  no beat held in either stage
// Optional build macro GFX_FB_WRITER_STATS_EN adds saturating counters
// stat_written (memory handshakes) and stat_clipped (beats dropped by clipping).
module gfx_fb_writer
    import gfx_fb_writer_pkg::*;
#(
    parameter int unsigned H_WIDTH     = GFX_H_WIDTH,
    parameter int unsigned V_WIDTH     = GFX_V_WIDTH,
    parameter int unsigned PIXEL_WIDTH = GFX_PIXEL_WIDTH,
    parameter int unsigned ADDR_WIDTH  = GFX_ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_gfx_valid,
    input  logic [H_WIDTH-1:0]     s_gfx_x,
    input  logic [V_WIDTH-1:0]     s_gfx_y,
    input  logic [PIXEL_WIDTH-1:0] s_gfx_pixel,
    output logic                   s_gfx_ready,
    input  logic [H_WIDTH-1:0]     h_visible,
    input  logic [V_WIDTH-1:0]     v_visible,
    input  logic [ADDR_WIDTH-1:0]  fb_base,
    output logic                   m_mem_valid,
    output logic [ADDR_WIDTH-1:0]  m_mem_addr,
    output logic [PIXEL_WIDTH-1:0] m_mem_data,
    input  logic                   m_mem_ready,
    output logic                   idle
`ifdef GFX_FB_WRITER_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]  stat_written,
    output logic [STAT_WIDTH-1:0]  stat_clipped
`endif
);

    // Stage A: captured input beat
    logic                   a_valid;
    logic [H_WIDTH-1:0]     a_x;
    logic [V_WIDTH-1:0]     a_y;
    logic [PIXEL_WIDTH-1:0] a_pixel;
    logic [ADDR_WIDTH-1:0]  a_base;

    // Stage B: pending memory write
    logic                   b_valid;
    logic [ADDR_WIDTH-1:0]  b_addr;
    logic [PIXEL_WIDTH-1:0] b_pixel;

    logic                   a_clip;
    logic [ADDR_WIDTH-1:0]  a_addr;
    logic                   b_ready;
    logic                   a_advance;
    logic                   a_to_b;
    logic                   s_accept;

    gfx_fb_addr #(
        .H_WIDTH    (H_WIDTH),
        .V_WIDTH    (V_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr (
        .x         (a_x),
        .y         (a_y),
        .h_visible (h_visible),
        .v_visible (v_visible),
        .fb_base   (a_base),
        .clip      (a_clip),
        .addr      (a_addr)
    );

    // A clipped beat leaves A without needing space in B, so clipping never
    // stalls the input even while memory back-pressures.
    always_comb begin
        b_ready     = !b_valid || m_mem_ready;
        a_advance   = a_valid && (a_clip || b_ready);
        a_to_b      = a_advance && !a_clip;
        s_gfx_ready = !a_valid || a_advance;
        s_accept    = s_gfx_valid && s_gfx_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_valid <= 1'b0;
            a_x     <= '0;
            a_y     <= '0;
            a_pixel <= '0;
            a_base  <= '0;
            b_valid <= 1'b0;
            b_addr  <= '0;
            b_pixel <= '0;
        end else begin
            if (s_accept) begin
                a_valid <= 1'b1;
                a_x     <= s_gfx_x;
                a_y     <= s_gfx_y;
                a_pixel <= s_gfx_pixel;
                a_base  <= fb_base;
            end else if (a_advance) begin
                a_valid <= 1'b0;
            end

            if (b_ready) begin
                b_valid <= a_to_b;
            end
            // Data registers only load on a real transfer so a stalled or
            // drained B keeps its last address and pixel.
            if (a_to_b) begin
                b_addr  <= a_addr;
                b_pixel <= a_pixel;
            end
        end
    end

    assign m_mem_valid = b_valid;
    assign m_mem_addr  = b_addr;
    assign m_mem_data  = b_pixel;
    assign idle        = !a_valid && !b_valid;

`ifdef GFX_FB_WRITER_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_written <= '0;
            stat_clipped <= '0;
        end else begin
            if (b_valid && m_mem_ready) begin
                stat_written <= sat_inc(stat_written);
            end
            if (a_advance && a_clip) begin
                stat_clipped <= sat_inc(stat_clipped);
            end
        end
    end
`endif

endmodule

// File: tb/tb_gfx_fb_writer.sv
module tb_gfx_fb_writer;

    logic        clk;
    logic        rst_n;
    logic        s_gfx_valid;
    logic [11:0] s_gfx_x;
    logic [11:0] s_gfx_y;
    logic [11:0] s_gfx_pixel;
    logic        s_gfx_ready;
    logic [11:0] h_visible;
    logic [11:0] v_visible;
    logic [23:0] fb_base;
    logic        m_mem_valid;
    logic [23:0] m_mem_addr;
    logic [11:0] m_mem_data;
    logic        m_mem_ready;
    logic        idle;
`ifdef GFX_FB_WRITER_STATS_EN
    logic [31:0] stat_written;
    logic [31:0] stat_clipped;
`endif

    gfx_fb_writer #(
        .H_WIDTH     (12),
        .V_WIDTH     (12),
        .PIXEL_WIDTH (12),
        .ADDR_WIDTH  (24)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_gfx_valid (s_gfx_valid),
        .s_gfx_x     (s_gfx_x),
        .s_gfx_y     (s_gfx_y),
        .s_gfx_pixel (s_gfx_pixel),
        .s_gfx_ready (s_gfx_ready),
        .h_visible   (h_visible),
        .v_visible   (v_visible),
        .fb_base     (fb_base),
        .m_mem_valid (m_mem_valid),
        .m_mem_addr  (m_mem_addr),
        .m_mem_data  (m_mem_data),
        .m_mem_ready (m_mem_ready),
        .idle        (idle)
`ifdef GFX_FB_WRITER_STATS_EN
        ,
        .stat_written (stat_written),
        .stat_clipped (stat_clipped)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [35:0] exp_q[$];       // {addr, data}
    int          hs_total = 0;
    int          cyc = 0;
    int          last_hs_edge = 0;
    int          exp_written = 0;
    int          exp_clipped = 0;
    bit          rand_ready = 0;
    bit          prev_stall = 0;
    logic [35:0] prev_out = '0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: linear address of a visible pixel, modulo 2^24.
    function automatic logic [23:0] ref_addr(input int base, input int x, input int y, input int h);
        longint full;
        full = longint'(base) + longint'(y) * longint'(h) + longint'(x);
        return full[23:0];
    endfunction

    // Scoreboard producer: every beat the DUT accepts is judged by the model.
    always @(negedge clk) begin
        if (rst_n && s_gfx_valid && s_gfx_ready) begin
            if (int'(s_gfx_x) < int'(h_visible) && int'(s_gfx_y) < int'(v_visible))
                exp_q.push_back({ref_addr(int'(fb_base), int'(s_gfx_x), int'(s_gfx_y),
                                          int'(h_visible)), s_gfx_pixel});
            else
                exp_clipped++;
        end
    end

    // Monitor: pops on each memory handshake and checks stall stability.
    always @(negedge clk) begin
        logic [35:0] exp_w;
        if (prev_stall)
            chk("stall_hold", {m_mem_valid, m_mem_addr, m_mem_data}, {1'b1, prev_out});
        if (rst_n && m_mem_valid && m_mem_ready) begin
            hs_total++;
            exp_written++;
            last_hs_edge = cyc + 1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%0h required=none", {m_mem_addr, m_mem_data});
            end else begin
                exp_w = exp_q.pop_front();
                chk("write", {m_mem_addr, m_mem_data}, exp_w);
            end
        end
        prev_stall = rst_n && m_mem_valid && !m_mem_ready;
        prev_out   = {m_mem_addr, m_mem_data};
    end

    // Random memory back-pressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) m_mem_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic set_beat(input int x, input int y, input logic [11:0] p);
        s_gfx_valid = 1'b1;
        s_gfx_x     = 12'(x);
        s_gfx_y     = 12'(y);
        s_gfx_pixel = p;
    endtask

    // Present a beat and return #1 after the edge that accepts it.
    task automatic send(input int x, input int y, input logic [11:0] p);
        int n;
        n = 0;
        set_beat(x, y, p);
        @(negedge clk);
        while (!s_gfx_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!s_gfx_ready) chk("send_timeout", 64'(s_gfx_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !idle) && n < 1000) begin
            n++;
            @(posedge clk);
            #1;
        end
        if (exp_q.size() != 0 || !idle) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int hs0, idx, first_edge, n;
        bit acc;

        rst_n       = 1'b0;
        s_gfx_valid = 1'b0;
        s_gfx_x     = '0;
        s_gfx_y     = '0;
        s_gfx_pixel = '0;
        h_visible   = 12'd640;
        v_visible   = 12'd480;
        fb_base     = '0;
        m_mem_ready = 1'b1;
        tick(3);

        chk("rst_valid", 64'(m_mem_valid), 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_ready", 64'(s_gfx_ready), 64'd1);
        chk("rst_addr_data", {m_mem_addr, m_mem_data}, 36'd0);
        rst_n = 1'b1;
        tick(1);

        // Single write with latency check
        send(10, 2, 12'hF00);
        s_gfx_valid = 1'b0;
        chk("lat_early", 64'(m_mem_valid), 64'd0);
        tick(1);
        chk("lat_valid", 64'(m_mem_valid), 64'd1);
        chk("single_addr_data", {m_mem_addr, m_mem_data}, {24'd1290, 12'hF00});
        tick(1);
        chk("single_idle", 64'(idle), 64'd1);

        // Clip boundaries
        hs0 = hs_total;
        send(640, 0, 12'h111);
        chk("clip_ready0", 64'(s_gfx_ready), 64'd1);
        send(0, 480, 12'h222);
        chk("clip_ready1", 64'(s_gfx_ready), 64'd1);
        send(639, 479, 12'h333);
        chk("clip_ready2", 64'(s_gfx_ready), 64'd1);
        s_gfx_valid = 1'b0;
        drain();
        chk("clip_writes", 64'(hs_total - hs0), 64'd1);

        // Backpressure: stalled memory lets exactly two beats in
        m_mem_ready = 1'b0;
        idx = 0;
        set_beat(idx, 7, 12'(idx + 12'h100));
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            acc = s_gfx_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                set_beat(idx, 7, 12'(idx + 12'h100));
            end
        end
        chk("bp_accepts", 64'(idx), 64'd2);
        chk("bp_ready_low", 64'(s_gfx_ready), 64'd0);
        m_mem_ready = 1'b1;
        for (int i = idx; i < 10; i++) send(i, 7, 12'(i + 12'h100));
        s_gfx_valid = 1'b0;
        drain();

        // Throughput
        hs0 = hs_total;
        send(0, 3, 12'h500);
        first_edge = cyc;
        for (int i = 1; i < 100; i++) send(i, 3, 12'(12'h500 + i));
        s_gfx_valid = 1'b0;
        n = 0;
        while (hs_total < hs0 + 100 && n < 500) begin
            n++;
            tick(1);
        end
        chk("tput_count", 64'(hs_total - hs0), 64'd100);
        chk("tput_cycles", 64'(last_hs_edge - first_edge), 64'd101);

        // Base wrap and mid-stream base change
        fb_base = 24'hFFFFF0;
        send(32, 0, 12'hABC);
        s_gfx_valid = 1'b0;
        tick(1);
        chk("wrap_addr", 64'(m_mem_addr), 64'h10);
        fb_base = 24'h001000;
        send(5, 1, 12'h0A1);
        fb_base = 24'h200000;
        send(5, 1, 12'h0A2);
        send(6, 1, 12'h0A3);
        s_gfx_valid = 1'b0;
        drain();

        // Zero-width visible area clips everything
        hs0 = hs_total;
        h_visible = 12'd0;
        v_visible = 12'd10;
        for (int i = 0; i < 5; i++) send(i, i, 12'(i));
        s_gfx_valid = 1'b0;
        drain();
        chk("hzero_writes", 64'(hs_total - hs0), 64'd0);

        // Randomized traffic with random back-pressure
        h_visible  = 12'd37;
        v_visible  = 12'd23;
        fb_base    = 24'(int'($urandom));
        rand_ready = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) fb_base = 24'(int'($urandom));
            if ($urandom_range(0, 4) == 0) begin
                s_gfx_valid = 1'b0;
                tick(1);
            end
            send($urandom_range(0, 40), $urandom_range(0, 26), 12'(int'($urandom)));
        end
        s_gfx_valid = 1'b0;
        rand_ready = 0;
        tick(1);
        m_mem_ready = 1'b1;
        drain();

        // Reset with both stages full and memory stalled
        h_visible   = 12'd640;
        v_visible   = 12'd480;
        fb_base     = 24'h000100;
        m_mem_ready = 1'b0;
        send(1, 1, 12'h777);
        send(2, 1, 12'h778);
        s_gfx_valid = 1'b0;
        chk("pre_rst_full", {63'd0, idle}, 64'd0);
        rst_n = 1'b0;
        tick(1);
        chk("mid_rst_valid", 64'(m_mem_valid), 64'd0);
        chk("mid_rst_idle", 64'(idle), 64'd1);
        chk("mid_rst_ready", 64'(s_gfx_ready), 64'd1);
        exp_q.delete();
        exp_written = 0;
        exp_clipped = 0;
        rst_n = 1'b1;
        m_mem_ready = 1'b1;
        tick(5);

        // Post-reset traffic
        send(3, 4, 12'h0C1);
        send(700, 4, 12'h0C2);
        send(4, 4, 12'h0C3);
        s_gfx_valid = 1'b0;
        drain();
        chk("final_queue", 64'(exp_q.size()), 64'd0);
`ifdef GFX_FB_WRITER_STATS_EN
        chk("stat_written", 64'(stat_written), 64'(exp_written));
        chk("stat_clipped", 64'(stat_clipped), 64'(exp_clipped));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
